// File: rtl/frv_pipeline_predecode_if.sv
// Fetch-buffer (s1) and decode-stage (s2) handshake between fetch and predecode.
// The predecode stage uses the slave modport; the driving environment uses master.
interface frv_pipeline_predecode_if;
  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s1_error;
  logic        s1_busy;
  logic        s1_flush;
  logic [31:0] s1_flush_target;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic [31:0] s2_pc;
  logic        s2_size;
  logic        s2_error;
  logic        s2_illegal;
  logic        s2_busy;

  modport master (
    output s1_valid, s1_data, s1_error, s1_flush, s1_flush_target, s2_busy,
    input  s1_busy, s2_valid, s2_instr, s2_pc, s2_size, s2_error, s2_illegal
  );

  modport slave (
    input  s1_valid, s1_data, s1_error, s1_flush, s1_flush_target, s2_busy,
    output s1_busy, s2_valid, s2_instr, s2_pc, s2_size, s2_error, s2_illegal
  );
endinterface

// File: rtl/frv_pipeline_predecode.sv
// Predecode stage: length decode, PC tracking, illegal/fault halt and one output register.
// FRV_PREDECODE_RVC_EN enables 16-bit compressed instructions; otherwise all are 32-bit.
//
// state | meaning
// RUN   | accepting instructions from the fetch buffer
// HALT  | faulting instruction held on s2; waiting for a redirect flush
module frv_pipeline_predecode #(
  parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000
) (
  input logic                    g_clk,
  input logic                    g_resetn,
  frv_pipeline_predecode_if.slave pd
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic [31:0] s2_pc_q, s2_pc_d;
  logic        s2_size_q, s2_size_d;
  logic        s2_error_q, s2_error_d;
  logic        s2_illegal_q, s2_illegal_d;

  logic        is32;
  logic        illegal_enc;
  logic [31:0] instr;
  logic        s1_busy;
  logic        accept;

  always_comb begin
`ifdef FRV_PREDECODE_RVC_EN
    is32        = (pd.s1_data[1:0] == 2'b11);
    illegal_enc = is32 ? (pd.s1_data[4:2] == 3'b111) : (pd.s1_data[15:0] == 16'h0000);
    instr       = is32 ? pd.s1_data : {16'h0000, pd.s1_data[15:0]};
`else
    is32        = 1'b1;
    illegal_enc = (pd.s1_data[1:0] != 2'b11) || (pd.s1_data[4:2] == 3'b111);
    instr       = pd.s1_data;
`endif
  end

  // FSM: state register
  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= RUN;
    else           state_q <= state_d;
  end

  // FSM: next state; a flush always returns to RUN
  always_comb begin
    state_d = state_q;
    if (pd.s1_flush)
      state_d = RUN;
    else if (accept && (pd.s1_error || illegal_enc))
      state_d = HALT;
  end

  // FSM: outputs
  always_comb begin
    s1_busy = (s2_valid_q && pd.s2_busy) || (state_q == HALT);
    accept  = pd.s1_valid && !s1_busy && !pd.s1_flush;
  end

  always_comb begin
    pc_d         = pc_q;
    s2_valid_d   = s2_valid_q;
    s2_instr_d   = s2_instr_q;
    s2_pc_d      = s2_pc_q;
    s2_size_d    = s2_size_q;
    s2_error_d   = s2_error_q;
    s2_illegal_d = s2_illegal_q;
    if (pd.s1_flush) begin
      // Masking keeps the target halfword-aligned without leaving bit 0 dangling.
      pc_d       = pd.s1_flush_target & 32'hFFFF_FFFE;
      s2_valid_d = 1'b0;
    end else if (accept) begin
      pc_d         = pc_q + (is32 ? 32'd4 : 32'd2);
      s2_valid_d   = 1'b1;
      s2_instr_d   = instr;
      s2_pc_d      = pc_q;
      s2_size_d    = is32;
      s2_error_d   = pd.s1_error;
      s2_illegal_d = illegal_enc && !pd.s1_error;
    end else if (s2_valid_q && !pd.s2_busy) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      pc_q         <= FRV_PC_RESET_VALUE;
      s2_valid_q   <= 1'b0;
      s2_instr_q   <= 32'h0;
      s2_pc_q      <= 32'h0;
      s2_size_q    <= 1'b0;
      s2_error_q   <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      s2_valid_q   <= s2_valid_d;
      s2_instr_q   <= s2_instr_d;
      s2_pc_q      <= s2_pc_d;
      s2_size_q    <= s2_size_d;
      s2_error_q   <= s2_error_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign pd.s1_busy    = s1_busy;
  assign pd.s2_valid   = s2_valid_q;
  assign pd.s2_instr   = s2_instr_q;
  assign pd.s2_pc      = s2_pc_q;
  assign pd.s2_size    = s2_size_q;
  assign pd.s2_error   = s2_error_q;
  assign pd.s2_illegal = s2_illegal_q;

endmodule

// File: tb/tb_frv_pipeline_predecode.sv
// Directed bench for frv_pipeline_predecode: a vector table of single instructions
// plus hand-written stall, flush, halt, wrap and reset sequences.
module tb_frv_pipeline_predecode;

  logic g_clk = 1'b0;
  logic g_resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 g_clk = ~g_clk;

  frv_pipeline_predecode_if pif ();

  frv_pipeline_predecode #(.FRV_PC_RESET_VALUE(32'h8000_0000)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .pd       (pif)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_instr;
    logic        exp_size;
    logic        exp_illegal;
    logic        exp_error;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    pif.s1_flush        = 1'b1;
    pif.s1_flush_target = tgt;
    step();
    pif.s1_flush        = 1'b0;
  endtask

  initial begin
`ifdef FRV_PREDECODE_RVC_EN
    vecs[0] = '{32'h0000_0013, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_001F, 1'b0, 32'h0000_001F, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_4501, 1'b0, 32'h0000_4501, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hABCD_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h1234_0002, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0013, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    vecs[0] = '{32'h0000_0013, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_001F, 1'b0, 32'h0000_001F, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_4501, 1'b0, 32'h0000_4501, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'hABCD_0000, 1'b0, 32'hABCD_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h1234_0002, 1'b0, 32'h1234_0002, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0013, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    g_resetn            = 1'b0;
    pif.s1_valid        = 1'b0;
    pif.s1_data         = 32'h0;
    pif.s1_error        = 1'b0;
    pif.s1_flush        = 1'b0;
    pif.s1_flush_target = 32'h0;
    pif.s2_busy         = 1'b0;
    step();
    step();

    chk("rst_s2_valid", {31'b0, pif.s2_valid}, 32'h0);
    chk("rst_s2_instr", pif.s2_instr, 32'h0);
    chk("rst_s2_pc", pif.s2_pc, 32'h0);
    chk("rst_s2_size", {31'b0, pif.s2_size}, 32'h0);
    chk("rst_s2_err_ill", {30'b0, pif.s2_error, pif.s2_illegal}, 32'h0);
    chk("rst_s1_busy", {31'b0, pif.s1_busy}, 32'h0);

    // First accept after reset uses the reset PC.
    g_resetn     = 1'b1;
    pif.s1_valid = 1'b1;
    pif.s1_data  = 32'h0000_0013;
    step();
    chk("first_valid", {31'b0, pif.s2_valid}, 32'h1);
    chk("first_pc", pif.s2_pc, 32'h8000_0000);
    chk("first_size", {31'b0, pif.s2_size}, 32'h1);

    // Downstream stall holds s2 and back-pressures s1.
    pif.s1_data = 32'h0000_0093;
    pif.s2_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_s1_busy", {31'b0, pif.s1_busy}, 32'h1);
      step();
      chk("stall_pc_held", pif.s2_pc, 32'h8000_0000);
      chk("stall_instr_held", pif.s2_instr, 32'h0000_0013);
    end
    pif.s2_busy = 1'b0;
    #1;
    chk("release_s1_busy", {31'b0, pif.s1_busy}, 32'h0);
    step();
    pif.s1_valid = 1'b0;
    chk("release_instr", pif.s2_instr, 32'h0000_0093);
    chk("release_pc", pif.s2_pc, 32'h8000_0004);
    step();
    chk("consumed_valid", {31'b0, pif.s2_valid}, 32'h0);

    // Flush beats a concurrent valid; target bit 0 is dropped.
    pif.s1_valid        = 1'b1;
    pif.s1_data         = 32'h0000_0013;
    pif.s1_flush        = 1'b1;
    pif.s1_flush_target = 32'h0000_1003;
    step();
    chk("flush_valid", {31'b0, pif.s2_valid}, 32'h0);
    pif.s1_flush = 1'b0;
    step();
    pif.s1_valid = 1'b0;
    chk("flush_pc", pif.s2_pc, 32'h0000_1002);
    chk("flush_acc_valid", {31'b0, pif.s2_valid}, 32'h1);
    step();

    // Fetch error halts until a flush.
    pif.s1_valid = 1'b1;
    pif.s1_error = 1'b1;
    step();
    pif.s1_error = 1'b0;
    chk("err_s2_error", {31'b0, pif.s2_error}, 32'h1);
    chk("err_s2_illegal", {31'b0, pif.s2_illegal}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_s1_busy", {31'b0, pif.s1_busy}, 32'h1);
      chk("halt_no_accept", {31'b0, pif.s2_valid}, 32'h0);
    end
    pif.s1_valid = 1'b0;
    do_flush(32'h0000_2000);
    chk("unhalt_s1_busy", {31'b0, pif.s1_busy}, 32'h0);
    pif.s1_valid = 1'b1;
    step();
    pif.s1_valid = 1'b0;
    chk("unhalt_pc", pif.s2_pc, 32'h0000_2000);
    step();

    // PC wraps through zero.
    do_flush(32'hFFFF_FFFC);
    pif.s1_valid = 1'b1;
    pif.s1_data  = 32'h0000_0013;
    step();
    chk("wrap_pc0", pif.s2_pc, 32'hFFFF_FFFC);
    step();
    pif.s1_valid = 1'b0;
    chk("wrap_pc1", pif.s2_pc, 32'h0000_0000);
    step();

`ifdef FRV_PREDECODE_RVC_EN
    // Compressed then full-width instruction: PC advances by 2.
    do_flush(32'h8000_0000);
    pif.s1_valid = 1'b1;
    pif.s1_data  = 32'h0000_4501;
    step();
    chk("rvc_pc0", pif.s2_pc, 32'h8000_0000);
    chk("rvc_size0", {31'b0, pif.s2_size}, 32'h0);
    pif.s1_data = 32'h0000_0013;
    step();
    pif.s1_valid = 1'b0;
    chk("rvc_pc1", pif.s2_pc, 32'h8000_0002);
    chk("rvc_size1", {31'b0, pif.s2_size}, 32'h1);
    step();
`endif

    for (int i = 0; i < 8; i++) begin
      do_flush(32'h0000_0100);
      pif.s1_valid = 1'b1;
      pif.s1_data  = vecs[i].data;
      pif.s1_error = vecs[i].err;
      step();
      pif.s1_valid = 1'b0;
      pif.s1_error = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, pif.s2_valid}, 32'h1);
      chk($sformatf("vec%0d_instr", i), pif.s2_instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_size", i), {31'b0, pif.s2_size}, {31'b0, vecs[i].exp_size});
      chk($sformatf("vec%0d_illegal", i), {31'b0, pif.s2_illegal}, {31'b0, vecs[i].exp_illegal});
      chk($sformatf("vec%0d_error", i), {31'b0, pif.s2_error}, {31'b0, vecs[i].exp_error});
      chk($sformatf("vec%0d_pc", i), pif.s2_pc, 32'h0000_0100);
      chk($sformatf("vec%0d_halt", i), {31'b0, pif.s1_busy}, {31'b0, vecs[i].exp_halt});
      step();
    end

    // Reset during a stall overrides flush and accept.
    do_flush(32'h0000_0200);
    pif.s1_valid = 1'b1;
    pif.s1_data  = 32'h0000_0013;
    step();
    pif.s2_busy         = 1'b1;
    g_resetn            = 1'b0;
    pif.s1_flush        = 1'b1;
    pif.s1_flush_target = 32'h0000_3000;
    step();
    chk("midrst_valid", {31'b0, pif.s2_valid}, 32'h0);
    chk("midrst_pc", pif.s2_pc, 32'h0);
    chk("midrst_instr", pif.s2_instr, 32'h0);
    g_resetn     = 1'b1;
    pif.s1_flush = 1'b0;
    pif.s2_busy  = 1'b0;
    step();
    pif.s1_valid = 1'b0;
    chk("postrst_pc", pif.s2_pc, 32'h8000_0000);
    chk("postrst_valid", {31'b0, pif.s2_valid}, 32'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frv_pipeline_predecode.md
FRV_PIPELINE_PREDECODE -- requirements
Module: frv_pipeline_predecode

Interface
REQ-001 The module SHALL have parameter FRV_PC_RESET_VALUE, default 32'h8000_0000, meaning the PC taken on reset.
REQ-002 The module SHALL have port g_clk, input, 1 bit, global clock, rising edge.
REQ-003 The module SHALL have port g_resetn, input, 1 bit, reset, synchronous, active-low.
REQ-004 The module SHALL have port s1_valid, input, 1 bit, fetch buffer holds a complete instruction.
REQ-005 The module SHALL have port s1_data, input, 32 bits, instruction bits, LSB-aligned.
REQ-006 The module SHALL have port s1_error, input, 1 bit, fetch bus error for this instruction.
REQ-007 The module SHALL have port s1_busy, output, 1 bit, predecode cannot accept this cycle.
REQ-008 The module SHALL have port s1_flush, input, 1 bit, control-flow redirect.
REQ-009 The module SHALL have port s1_flush_target, input, 32 bits, new PC on redirect.
REQ-010 The module SHALL have port s2_valid, output, 1 bit, output register holds an instruction.
REQ-011 The module SHALL have port s2_instr, output, 32 bits, instruction; 16-bit forms are zero-extended in [31:16].
REQ-012 The module SHALL have ports s2_pc (output, 32 bits, instruction PC) and s2_size (output, 1 bit, 1 = 32-bit instruction, 0 = 16-bit).
REQ-013 The module SHALL have ports s2_error (output, 1 bit, fetch fault) and s2_illegal (output, 1 bit, illegal encoding).
REQ-014 The module SHALL have port s2_busy, input, 1 bit, downstream stall.

Function
REQ-015 Accept condition: s1_valid && !s1_busy && !s1_flush; s1_busy = (s2_valid && s2_busy) || state==HALT.
REQ-016 Accepted instruction SHALL appear on s2_* the next cycle (1-cycle latency); s2_* held stable while s2_valid && s2_busy.
REQ-017 s2_valid SHALL clear the cycle after consumption (s2_valid && !s2_busy) when no new accept occurs.
REQ-018 Length: s1_data[1:0]==2'b11 -> 32-bit; otherwise 16-bit.
REQ-019 Internal PC SHALL advance by 4 (32-bit) or 2 (16-bit) on each accept, modulo 2^32; wrap from 32'hFFFF_FFFE to 0 is legal.
REQ-020 s1_flush SHALL load PC with {s1_flush_target[31:1],1'b0}, clear s2_valid next cycle, and force state RUN; flush wins over a simultaneous accept.
REQ-021 States RUN and HALT: RUN->HALT on accepting an instruction with s1_error or illegal encoding; HALT->RUN only on s1_flush.
REQ-022 In HALT the faulting instruction SHALL remain on s2_* until consumed; no further instructions accepted.
REQ-023 s2_illegal SHALL be 1 for 16-bit instruction bits 16'h0000, and for any 32-bit instruction with s1_data[4:2]==3'b111.
REQ-024 s2_error takes precedence; s2_illegal SHALL be 0 whenever s2_error is 1.

Reset
REQ-025 On reset: s2_valid=0, state=RUN, PC=FRV_PC_RESET_VALUE, s2_instr/s2_pc/s2_size/s2_error/s2_illegal=0.
REQ-026 Reset asserted mid-operation SHALL discard the held instruction in the same edge, overriding flush and accept.

Configuration
REQ-027 Macro FRV_PREDECODE_RVC_EN defined: 16-bit instructions accepted per REQ-018 to REQ-023.
REQ-028 Macro FRV_PREDECODE_RVC_EN undefined: every instruction treated as 32-bit (PC +4), and s1_data[1:0]!=2'b11 sets s2_illegal and enters HALT.

Verification
REQ-029 Reset, s1_valid=1, s1_data=32'h0000_0013 -> next cycle s2_valid=1, s2_pc=32'h8000_0000, s2_size=1.
REQ-030 RVC on: accept 16'h4501 then 32'h0000_0013 -> s2_pc 32'h8000_0000 then 32'h8000_0002, s2_size 0 then 1.
REQ-031 s2_busy=1 for 3 cycles with s1_valid=1 -> s1_busy=1, s2_* unchanged; release -> next instruction accepted.
REQ-032 s1_flush with target 32'h0000_1003 concurrent with s1_valid -> s2_valid=0 next cycle; next accept gives s2_pc=32'h0000_1002.
REQ-033 Accept with s1_error=1 -> s2_error=1, s2_illegal=0, s1_busy stays 1 until s1_flush, then RUN.
REQ-034 RVC off: s1_data=32'h0000_4501 -> s2_illegal=1, HALT; PC advanced by 4.
